alu_cmd_sequencer: RTL and testbench

Command issue and result capture stage wrapped around the combinational 16-bit ALU/FPU. It buffers incoming `{op, a, b}` commands in a small FIFO and presents the head entry to the ALU. It registers the ALU's result and flags into a response slot with valid/ready backpressure. It keeps a running result register, so CNN accumulation chains (sum-of-products partials, FP_ADD chains) can reuse the previous result as operand `a`.

---
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO, issue and response-capture stage wrapped around a combinational ALU.
// Chained commands take operand a from the running result register at their own issue cycle.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OP_W-1:0]            cmd_op,
  input  logic [DATA_W-1:0]          cmd_a,
  input  logic [DATA_W-1:0]          cmd_b,
  input  logic                       cmd_chain,
  output logic [OP_W-1:0]            alu_op,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  input  logic [DATA_W-1:0]          alu_result,
  input  logic                       alu_zero,
  input  logic                       alu_carry,
  input  logic                       alu_fp_error,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_result,
  output logic                       rsp_zero,
  output logic                       rsp_carry,
  output logic                       rsp_fp_error,
  output logic [DATA_W-1:0]          acc,
  output logic                       sticky_fp_error,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = OP_W + 2 * DATA_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               rsp_fp_error_q, rsp_fp_error_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               sticky_q, sticky_d;

  logic               push, issue, slot_free, fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [OP_W-1:0]    head_op;
  logic [DATA_W-1:0]  head_a, head_b;
  logic               head_chain;

  // No full-bypass: a pop in the same cycle never makes room for a push.
  assign cmd_ready  = (count_q < CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid && cmd_ready;
  assign slot_free  = !rsp_valid_q || rsp_ready;
  assign issue      = !fifo_empty && slot_free;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b, cmd_chain};
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign {head_op, head_a, head_b, head_chain} = head;

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (!fifo_empty) begin
      alu_op = head_op;
      alu_a  = head_chain ? acc_q : head_a;
      alu_b  = head_b;
    end
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_fp_error_d = rsp_fp_error_q;
    acc_d          = acc_q;
    sticky_d       = sticky_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !issue) count_d = count_q + 1'b1;
    else if (!push && issue) count_d = count_q - 1'b1;

    if (issue) begin
      rsp_valid_d    = 1'b1;
      rsp_result_d   = alu_result;
      rsp_zero_d     = alu_zero;
      rsp_carry_d    = alu_carry;
      rsp_fp_error_d = alu_fp_error;
      acc_d          = alu_result;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    // A new error capture outranks a clear request in the same cycle.
    if (issue && alu_fp_error) sticky_d = 1'b1;
    else if (clr_sticky) sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_fp_error_q <= 1'b0;
      acc_q          <= '0;
      sticky_q       <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_fp_error_q <= rsp_fp_error_d;
      acc_q          <= acc_d;
      sticky_q       <= sticky_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_zero        = rsp_zero_q;
  assign rsp_carry       = rsp_carry_q;
  assign rsp_fp_error    = rsp_fp_error_q;
  assign acc             = acc_q;
  assign sticky_fp_error = sticky_q;
  assign count           = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small ALU stub:
// op 0 ADD, 1 SUB (carry = borrow), 2 XOR, 3 ADD that also raises fp_error.
module tb_alu_cmd_sequencer;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_ERR = 4'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        cmd_chain = 1'b0;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_zero, alu_carry, alu_fp_error;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_zero, rsp_carry, rsp_fp_error;
  logic [15:0] acc;
  logic        sticky_fp_error;
  logic        clr_sticky = 1'b0;
  logic [2:0]  count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  alu_cmd_sequencer #(.DEPTH(4), .DATA_W(16), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_fp_error(alu_fp_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_fp_error(rsp_fp_error),
    .acc(acc), .sticky_fp_error(sticky_fp_error), .clr_sticky(clr_sticky),
    .count(count)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [16:0] wide;
    wide         = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_fp_error = 1'b0;
    case (alu_op)
      OP_ADD, OP_ERR: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = wide[15:0];
        alu_carry    = wide[16];
        alu_fp_error = (alu_op == OP_ERR);
      end
      OP_SUB: begin
        alu_result = alu_a - alu_b;
        alu_carry  = (alu_a < alu_b);
      end
      OP_XOR: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic chain);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
  endtask

  initial begin
    logic [15:0] exp_q[$];
    int accepted, recv, sent, cyc;

    // Reset
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst_count", 32'(count), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_result", 32'(rsp_result), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_sticky", 32'(sticky_fp_error), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_alu_op", 32'(alu_op), 0);
    $display("reset: count=%0d rsp_valid=%0b acc=0x%04h", count, rsp_valid, acc);

    // Single ADD latency
    rsp_ready = 1'b1;
    drive(OP_ADD, 16'h0005, 16'h0003, 1'b0);
    step();
    cmd_valid = 1'b0;
    check("lat_not_yet_valid", 32'(rsp_valid), 0);
    check("lat_head_a", 32'(alu_a), 32'h5);
    step();
    check("lat_rsp_valid", 32'(rsp_valid), 1);
    check("lat_result", 32'(rsp_result), 32'h8);
    check("lat_zero", 32'(rsp_zero), 0);
    check("lat_carry", 32'(rsp_carry), 0);
    check("lat_acc", 32'(acc), 32'h8);
    $display("add 5+3: rsp=0x%04h acc=0x%04h", rsp_result, acc);
    step();
    check("lat_drain", 32'(rsp_valid), 0);

    // Chain
    drive(OP_ADD, 16'h0005, 16'h0003, 1'b0);
    step();
    drive(OP_ADD, 16'h1234, 16'h0002, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("chain_rsp0", 32'(rsp_result), 32'h8);
    $display("chain rsp0=0x%04h", rsp_result);
    step();
    check("chain_rsp1", 32'(rsp_result), 32'hA);
    check("chain_rsp1_valid", 32'(rsp_valid), 1);
    $display("chain rsp1=0x%04h", rsp_result);
    drive(OP_SUB, 16'h4321, 16'h000B, 1'b1);
    step();
    cmd_valid = 1'b0;
    step();
    check("chain_sub", 32'(rsp_result), 32'hFFFF);
    check("chain_sub_carry", 32'(rsp_carry), 1);
    check("chain_sub_acc", 32'(acc), 32'hFFFF);
    $display("chain sub rsp=0x%04h carry=%0b", rsp_result, rsp_carry);
    step();

    // Backpressure: offer 6 commands with the consumer stalled
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      drive(OP_ADD, 16'(16'h0100 + i), 16'h0001, 1'b0);
      if (cmd_ready) begin
        exp_q.push_back(16'(16'h0101 + i));
        accepted++;
      end
      step();
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 5);
    check("bp_cmd_ready", 32'(cmd_ready), 0);
    check("bp_count", 32'(count), 4);
    check("bp_slot_valid", 32'(rsp_valid), 1);
    check("bp_slot_result", 32'(rsp_result), 32'h0101);
    step(); step();
    check("bp_stable_valid", 32'(rsp_valid), 1);
    check("bp_stable_result", 32'(rsp_result), 32'h0101);
    rsp_ready = 1'b1;
    recv = 0;
    cyc = 0;
    while (recv < 5 && cyc < 50) begin
      if (rsp_valid) begin
        check("bp_order", 32'(rsp_result), 32'(exp_q.pop_front()));
        $display("bp rsp[%0d]=0x%04h", recv, rsp_result);
        recv++;
      end
      step();
      cyc++;
    end
    check("bp_recv_all", 32'(recv), 5);
    check("bp_no_extra", 32'(rsp_valid), 0);

    // Wrap-around with random consumer backpressure
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 20 && cyc < 400) begin
      rsp_ready = 1'($urandom_range(0, 1));
      if (sent < 20) drive(OP_XOR, 16'(sent), 16'h00FF, 1'b0);
      else cmd_valid = 1'b0;
      if (rsp_valid && rsp_ready) begin
        check("wrap_result", 32'(rsp_result), 32'(16'(recv) ^ 16'h00FF));
        $display("wrap rsp[%0d]=0x%04h", recv, rsp_result);
        recv++;
      end
      check("wrap_count_max", 32'(count <= 3'd4), 1);
      if (cmd_valid && cmd_ready) sent++;
      step();
      cyc++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("wrap_recv_all", 32'(recv), 20);
    step(); step();

    // Sticky fp_error
    drive(OP_ERR, 16'h0001, 16'h0001, 1'b0);
    step();
    cmd_valid = 1'b0;
    step();
    check("sticky_set", 32'(sticky_fp_error), 1);
    check("sticky_rsp_fp", 32'(rsp_fp_error), 1);
    drive(OP_ADD, 16'h0002, 16'h0002, 1'b0);
    step();
    cmd_valid = 1'b0;
    step();
    check("sticky_hold", 32'(sticky_fp_error), 1);
    check("sticky_clean_rsp", 32'(rsp_fp_error), 0);
    drive(OP_ERR, 16'h0003, 16'h0003, 1'b0);
    step();
    cmd_valid = 1'b0;
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("sticky_set_wins", 32'(sticky_fp_error), 1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("sticky_cleared", 32'(sticky_fp_error), 0);
    $display("sticky after clear=%0b", sticky_fp_error);

    // Reset mid-stream
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(OP_ADD, 16'h0007, 16'(i), 1'b0);
      step();
    end
    cmd_valid = 1'b0;
    check("mid_count", 32'(count), 3);
    check("mid_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_acc", 32'(acc), 0);
    check("mid_rst_alu_op", 32'(alu_op), 0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_stale", 32'(rsp_valid), 0);
    end
    $display("mid reset: count=%0d rsp_valid=%0b", count, rsp_valid);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
